uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter, the send-side counterpart of the team's UART receiver. It accepts a byte through a valid/ready handshake and serialises it on the line as 8N1 by default: start bit, LSB-first data, stop bit(s). Bit timing comes from the same run-time SYMBOL_WIDTH input the receiver uses (clocks per bit = clk_freq/baud_rate). The output line idles high.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..8; data taken from d_in[DATA_BITS-1:0]
STOP_BITS, 1, stop bits per frame, legal 1 or 2

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
SYMBOL_WIDTH  input  16  clocks per bit; sampled at byte acceptance
send_req  input  1  byte on d_in is valid
d_in  input  8  byte to transmit
send_ack  output  1  ready; a byte is accepted on any clock edge where send_req && send_ack
Tx  output  1  serial line, registered, idle high
busy  output  1  frame in progress (START, DATA or STOP state)
done  output  1  one-cycle pulse in the last clock of the final stop bit

Behaviour:
- Reset, asynchronous and immediate, including mid-frame:
  - Tx=1, busy=0, done=0, send_ack=1, state=IDLE.
  - Bit counter, symbol counter and shift register clear to 0.
  - A partial frame is abandoned. Tx returning high mid-frame is acceptable.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: send_ack=1, Tx=1. On accept, latch d_in into the shift register and latch sw = max(SYMBOL_WIDTH, 2); go to START.
  - START: Tx=0 for sw clocks, then DATA.
  - DATA: Tx=shift[0] for sw clocks per bit. Shift right after each bit. Counter i runs 0..DATA_BITS-1; after bit DATA_BITS-1, go to STOP.
  - STOP: Tx=1 for STOP_BITS*sw clocks.
- Latency: Tx is registered. Tx falls on the clock edge after the accepting edge, so the first start-bit clock is the cycle after acceptance.
- Bit timing:
  - Symbol counter t runs 0..sw-1. The bit ends when t==sw-1; t then wraps to 0.
  - Every bit lasts exactly sw clocks.
  - Frame length = (1+DATA_BITS+STOP_BITS)*sw clocks.
- Width rules:
  - Counter t is 16 bits; comparisons are against sw-1 in 16 bits.
  - SYMBOL_WIDTH = 0 or 1 is treated as 2.
  - SYMBOL_WIDTH changes during a frame have no effect on that frame.
- Back-to-back handshake:
  - send_ack is also asserted in the last clock of the final stop bit, coincident with done.
  - If send_req is high then, the next byte is accepted and START begins the next cycle, with no idle gap.
  - Otherwise the FSM goes to IDLE, and send_ack stays 1.
- Outside IDLE and the last stop clock: send_ack=0; send_req and d_in are ignored and not queued.
- d_in may change freely after acceptance; only the latched copy is sent.
- busy=1 from the cycle after acceptance through the last stop clock. busy stays 1 across back-to-back frames.
- done: exactly one pulse per completed frame; never asserted for a frame aborted by reset.
- send_req held high with send_ack low: no effect until send_ack rises.

Test Plan:
1. Reset, then hold SYMBOL_WIDTH=4 and pulse send_req with d_in=8'hA5 -> Tx sequence over 40 clocks, each level held 4 clocks: 0,1,0,1,0,0,1,0,1,1. done pulses at clock 40 after acceptance; busy is high for clocks 1..40.
2. SYMBOL_WIDTH=3, send 8'h00 with send_req held high and d_in changed to 8'hFF for the second byte -> the second frame's start bit begins immediately after clock 30, with no idle-high gap; second frame data bits all 1; two done pulses, 30 clocks apart.
3. Start sending 8'h3C with SYMBOL_WIDTH=5; change SYMBOL_WIDTH to 2 and toggle send_req/d_in mid-frame -> frame still uses 5-clock bits and transmits 0x3C; no extra byte is sent.
4. Assert rst during data bit 3 of a frame -> Tx=1 and busy=0 in the same cycle, asynchronously; no done pulse. A new byte 8'h81 sent after reset produces a correct full frame.
5. SYMBOL_WIDTH=0 and 1, send 8'h55 -> each bit lasts 2 clocks; frame is 20 clocks.
6. STOP_BITS=2, DATA_BITS=7, SYMBOL_WIDTH=4, send 8'hFF -> 7 data bits of 1, then 8 clocks of stop; frame is 40 clocks; send_ack high only in the final stop clock.

Source files
------------

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// A byte moves on any rising clk edge where send_req && send_ack.
interface uart_tx_if;
  logic       send_req;
  logic [7:0] d_in;
  logic       send_ack;

  modport master (
    output send_req,
    output d_in,
    input  send_ack
  );

  modport slave (
    input  send_req,
    input  d_in,
    output send_ack
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, stop bit(s); bit period latched
// from SYMBOL_WIDTH at byte acceptance (minimum 2 clocks).
//
// state | meaning
// IDLE  | line high, ready for a byte
// START | start bit (line low) for sw clocks
// DATA  | data bit i (shift[0]) for sw clocks, i = 0..DATA_BITS-1
// STOP  | line high, stop bit i for sw clocks, i = 0..STOP_BITS-1
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] SYMBOL_WIDTH,
  uart_tx_if.slave    host,
  output logic        Tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);

  state_t      state, state_n;
  logic [15:0] t, t_n;
  logic [15:0] sw, sw_n;
  logic [2:0]  i, i_n;
  logic [7:0]  shift, shift_n;
  logic        tx_q, tx_n;

  logic [15:0] sw_req;
  logic        bit_end;
  logic        last_stop;
  logic        accept;

  assign sw_req    = (SYMBOL_WIDTH < 16'd2) ? 16'd2 : SYMBOL_WIDTH;
  assign bit_end   = (t == sw - 16'd1);
  assign last_stop = (state == STOP) && bit_end && (i == LAST_STOP);

  // Ready in the last stop clock as well, so frames can run back to back.
  assign host.send_ack = (state == IDLE) || last_stop;
  assign accept        = host.send_req && host.send_ack;

  assign busy = (state != IDLE);
  assign done = last_stop;
  assign Tx   = tx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      t     <= '0;
      sw    <= '0;
      i     <= '0;
      shift <= '0;
      tx_q  <= 1'b1;
    end else begin
      state <= state_n;
      t     <= t_n;
      sw    <= sw_n;
      i     <= i_n;
      shift <= shift_n;
      tx_q  <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    t_n     = t;
    sw_n    = sw;
    i_n     = i;
    shift_n = shift;

    case (state)
      IDLE: begin
        if (accept) begin
          shift_n = host.d_in & DATA_MASK;
          sw_n    = sw_req;
          t_n     = '0;
          i_n     = '0;
          state_n = START;
        end
      end

      START: begin
        if (bit_end) begin
          t_n     = '0;
          i_n     = '0;
          state_n = DATA;
        end else begin
          t_n = t + 16'd1;
        end
      end

      DATA: begin
        if (bit_end) begin
          t_n     = '0;
          shift_n = {1'b0, shift[7:1]};
          if (i == LAST_DATA) begin
            i_n     = '0;
            state_n = STOP;
          end else begin
            i_n = i + 3'd1;
          end
        end else begin
          t_n = t + 16'd1;
        end
      end

      STOP: begin
        if (bit_end) begin
          t_n = '0;
          if (i == LAST_STOP) begin
            i_n = '0;
            if (accept) begin
              shift_n = host.d_in & DATA_MASK;
              sw_n    = sw_req;
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            i_n = i + 3'd1;
          end
        end else begin
          t_n = t + 16'd1;
        end
      end

      default: begin
        state_n = IDLE;
        t_n     = '0;
        i_n     = '0;
      end
    endcase

    // Line level for the coming cycle, registered so Tx is glitch-free.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized and directed bench for uart_tx; a waveform-queue model predicts
// Tx/busy/done/send_ack for every cycle of two instances (8N1 and 7N2).
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sym_w = 16'd4;

  uart_tx_if if_a ();
  uart_tx_if if_b ();

  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .SYMBOL_WIDTH (sym_w),
    .host         (if_a),
    .Tx           (tx_a),
    .busy         (busy_a),
    .done         (done_a)
  );

  uart_tx #(.DATA_BITS(7), .STOP_BITS(2)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .SYMBOL_WIDTH (sym_w),
    .host         (if_b),
    .Tx           (tx_b),
    .busy         (busy_b),
    .done         (done_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: each queue entry is one future clock of line activity {done, tx}.
  // An empty queue means idle; a single entry is the last stop clock.
  logic [1:0] qa[$];
  logic [1:0] qb[$];
  logic       acc_a, acc_b;
  int         swm_a, swm_b;

  function automatic logic frame_level(input logic [7:0] d, input int dbits, input int k);
    if (k == 0) return 1'b0;
    if (k <= dbits) return d[k-1];
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa.delete();
    end else begin
      acc_a = if_a.send_req && (qa.size() <= 1);
      if (qa.size() > 0) void'(qa.pop_front());
      if (acc_a) begin
        swm_a = (sym_w < 16'd2) ? 2 : int'(sym_w);
        for (int k = 0; k < 10; k++)
          for (int s = 0; s < swm_a; s++)
            qa.push_back({1'((k == 9) && (s == swm_a - 1)), frame_level(if_a.d_in, 8, k)});
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qb.delete();
    end else begin
      acc_b = if_b.send_req && (qb.size() <= 1);
      if (qb.size() > 0) void'(qb.pop_front());
      if (acc_b) begin
        swm_b = (sym_w < 16'd2) ? 2 : int'(sym_w);
        for (int k = 0; k < 10; k++)
          for (int s = 0; s < swm_b; s++)
            qb.push_back({1'((k == 9) && (s == swm_b - 1)), frame_level(if_b.d_in, 7, k)});
      end
    end
  end

  logic [1:0] ha, hb;

  always @(negedge clk) begin
    if (!rst) begin
      ha = (qa.size() > 0) ? qa[0] : 2'b01;
      hb = (qb.size() > 0) ? qb[0] : 2'b01;
      chk("model_a_tx",   tx_a,          ha[0]);
      chk("model_a_done", done_a,        ha[1]);
      chk("model_a_busy", busy_a,        qa.size() > 0);
      chk("model_a_ack",  if_a.send_ack, qa.size() <= 1);
      chk("model_b_tx",   tx_b,          hb[0]);
      chk("model_b_done", done_b,        hb[1]);
      chk("model_b_busy", busy_b,        qb.size() > 0);
      chk("model_b_ack",  if_b.send_ack, qb.size() <= 1);
    end
  end

  task automatic set_req(input bit sel, input logic v);
    if (sel) if_b.send_req = v;
    else     if_a.send_req = v;
  endtask

  task automatic set_data(input bit sel, input logic [7:0] d);
    if (sel) if_b.d_in = d;
    else     if_a.d_in = d;
  endtask

  // Returns at the negedge before the accepting edge.
  task automatic wait_ack(input bit sel);
    bit ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if ((sel ? if_b.send_ack : if_a.send_ack) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL ack_timeout sel=%0d: got send_ack low for 400 cycles, expected high", sel);
    end
  endtask

  // Leaves time at accepting edge + 2, with send_req dropped.
  task automatic send(input bit sel, input logic [7:0] d, input logic [15:0] w);
    @(posedge clk);
    #2;
    sym_w = w;
    set_data(sel, d);
    set_req(sel, 1'b1);
    wait_ack(sel);
    @(posedge clk);
    #2;
    set_req(sel, 1'b0);
  endtask

  // lv[k] is the hand-computed line level of symbol k (start, data, stops).
  task automatic expect_frame(input bit sel, input logic [9:0] lv, input int sw, input bit wiggle);
    int len = 10 * sw;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      chk("frame_tx",   sel ? tx_b : tx_a,                   lv[(c-1)/sw]);
      chk("frame_busy", sel ? busy_b : busy_a,               1'b1);
      chk("frame_done", sel ? done_b : done_a,               c == len);
      chk("frame_ack",  sel ? if_b.send_ack : if_a.send_ack, c == len);
      if (wiggle) begin
        if (c < 9 * sw) begin
          sym_w = 16'($urandom_range(0, 6));
          set_req(sel, 1'($urandom_range(0, 1)));
          set_data(sel, 8'($urandom));
        end else begin
          set_req(sel, 1'b0);
        end
      end
    end
  endtask

  task automatic idle_check(input bit sel);
    @(negedge clk);
    chk("idle_tx",   sel ? tx_b : tx_a,                   1'b1);
    chk("idle_busy", sel ? busy_b : busy_a,               1'b0);
    chk("idle_ack",  sel ? if_b.send_ack : if_a.send_ack, 1'b1);
  endtask

  initial begin
    if_a.send_req = 1'b0;
    if_a.d_in     = 8'h00;
    if_b.send_req = 1'b0;
    if_b.d_in     = 8'h00;

    #23;
    chk("rst_tx_a",   tx_a,          1'b1);
    chk("rst_busy_a", busy_a,        1'b0);
    chk("rst_done_a", done_a,        1'b0);
    chk("rst_ack_a",  if_a.send_ack, 1'b1);
    chk("rst_tx_b",   tx_b,          1'b1);
    chk("rst_ack_b",  if_b.send_ack, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // 0xA5, 4 clocks per bit
    send(1'b0, 8'hA5, 16'd4);
    expect_frame(1'b0, 10'b1_10100101_0, 4, 1'b0);
    idle_check(1'b0);

    // back-to-back 0x00 then 0xFF with send_req held
    @(posedge clk);
    #2;
    sym_w = 16'd3;
    if_a.d_in = 8'h00;
    if_a.send_req = 1'b1;
    wait_ack(1'b0);
    @(posedge clk);
    #2;
    if_a.d_in = 8'hFF;
    expect_frame(1'b0, 10'b1_00000000_0, 3, 1'b0);
    @(posedge clk);
    #2;
    if_a.send_req = 1'b0;
    expect_frame(1'b0, 10'b1_11111111_0, 3, 1'b0);
    idle_check(1'b0);

    // 0x3C at width 5 while width, send_req and d_in churn mid-frame
    send(1'b0, 8'h3C, 16'd5);
    expect_frame(1'b0, 10'b1_00111100_0, 5, 1'b1);
    idle_check(1'b0);
    idle_check(1'b0);

    // reset during data bit 3 (clocks 17..20 at width 4)
    send(1'b0, 8'h6B, 16'd4);
    for (int c = 1; c <= 18; c++) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_tx",   tx_a,   1'b1);
    chk("async_rst_busy", busy_a, 1'b0);
    chk("async_rst_done", done_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle_check(1'b0);
    send(1'b0, 8'h81, 16'd4);
    expect_frame(1'b0, 10'b1_10000001_0, 4, 1'b0);
    idle_check(1'b0);

    // widths 0 and 1 clamp to 2
    send(1'b0, 8'h55, 16'd0);
    expect_frame(1'b0, 10'b1_01010101_0, 2, 1'b0);
    idle_check(1'b0);
    send(1'b0, 8'h55, 16'd1);
    expect_frame(1'b0, 10'b1_01010101_0, 2, 1'b0);
    idle_check(1'b0);

    // 7 data bits, 2 stop bits, 0xFF at width 4
    send(1'b1, 8'hFF, 16'd4);
    expect_frame(1'b1, 10'b11_1111111_0, 4, 1'b0);
    idle_check(1'b1);

    // random traffic on both instances, with occasional resets
    for (int n = 0; n < 2500; n++) begin
      @(posedge clk);
      #2;
      if_a.send_req = ($urandom_range(0, 3) != 0);
      if_a.d_in     = 8'($urandom);
      if_b.send_req = ($urandom_range(0, 2) != 0);
      if_b.d_in     = 8'($urandom);
      if ($urandom_range(0, 15) == 0) sym_w = 16'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    @(posedge clk);
    #2;
    if_a.send_req = 1'b0;
    if_b.send_req = 1'b0;
    repeat (100) @(posedge clk);
    idle_check(1'b0);
    idle_check(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
